muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; the datapath is fixed at 32 bits.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high; clears all state and outputs.
REQ-005 start  input  1  request to begin an operation; accepted only in IDLE.
REQ-006 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_data  input  32  first operand, fed from the register file's rd1_data.
REQ-008 rs2_data  input  32  second operand, fed from the register file's rd2_data.
REQ-009 rd_addr  input  5  destination register index.
REQ-010 busy  output  1  high in every non-IDLE state.
REQ-011 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-012 result  output  32  operation result.
REQ-013 result_addr  output  5  destination index latched at accept.
REQ-014 reg_write_en  output  1  equals done AND (result_addr != 0); drives the register-file write enable.

Function
REQ-015 Acceptance: start=1 in IDLE at edge T latches funct3, rs1_data, rs2_data and rd_addr; later input changes have no effect on the operation.
REQ-016 Busy rejection: start while busy is ignored, with no state change and no queueing.
REQ-017 States: IDLE, MUL, DIV, DONE.
REQ-018 Transitions: IDLE->MUL for funct3[2]=0; IDLE->DIV for funct3[2]=1, except special cases (REQ-022); MUL/DIV->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-019 Latency, normal path: one iteration per cycle, at T+1..T+32; done=1 during T+33; busy=1 during T+1..T+33; IDLE again at T+34.
REQ-020 Multiply: iterative shift-add on operand magnitudes, producing a 64-bit product, then sign correction.
- MUL returns bits [31:0].
- MULH returns bits [63:32], signed x signed.
- MULHSU returns bits [63:32], signed rs1 x unsigned rs2.
- MULHU returns bits [63:32], unsigned x unsigned.
REQ-021 Divide: restoring, one quotient bit per cycle on magnitudes.
- Quotient sign = sign(rs1) XOR sign(rs2).
- Remainder sign = sign(rs1).
- DIV/DIVU return the quotient; REM/REMU return the remainder.
REQ-022 Special cases: these skip the iterations, go IDLE->DONE, and assert done at T+1.
- Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-023 Output hold: result and result_addr hold their values after done until the next done; done and reg_write_en are 0 outside DONE.
REQ-024 Back-to-back: start asserted during DONE is ignored; the earliest next accept is the edge at which the unit is in IDLE.
REQ-025 All arithmetic is modulo 2^32 on the 32-bit outputs; no exceptions or flags are raised.

Reset
REQ-026 With reset=1 at a rising edge, on the next cycle: state=IDLE, busy=0, done=0, reg_write_en=0, result=0, result_addr=0.
REQ-027 Reset mid-operation aborts the operation with no done pulse; reset has priority over start in the same cycle.

Verification
REQ-028 MUL: rs1=7, rs2=0xFFFFFFFD, rd_addr=5 -> at T+33, result=0xFFFFFFEB, done=1, reg_write_en=1, result_addr=5.
REQ-029 MULHU: rs1=rs2=0xFFFFFFFF -> result=0xFFFFFFFE at T+33; MULH with the same operands -> result=0x00000000.
REQ-030 Special cases:
- DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000, done at T+1.
- DIVU 9 / 0 -> result=0xFFFFFFFF at T+1.
- REMU 9 / 0 -> result=9 at T+1.
REQ-031 DIV/REM: rs1=0xFFFFFFF9 (-7), rs2=2 -> DIV gives 0xFFFFFFFD, REM gives 0xFFFFFFFF, both at T+33.
REQ-032 Busy and x0: a second start at T+5 is ignored and only one done is seen, at T+33; with rd_addr=0, done=1 while reg_write_en=0.
REQ-033 Reset: reset asserted at T+10 of a MUL -> busy=0 next cycle, no done pulse, result=0; a new start after reset completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with sign correction at the end.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  result_addr,
  output logic        reg_write_en,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic        sign_q;
  logic        sign_r;
  logic [31:0] hi_q, lo_q, b_q;
  logic [4:0]  count_q;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_res;

  // Operand decode at accept time: signedness, magnitudes and the short-cut cases.
  always_comb begin
    if (funct3[2]) begin
      a_signed = ~funct3[0];
      b_signed = ~funct3[0];
    end else begin
      a_signed = (funct3[1:0] != 2'b11);
      b_signed = ~funct3[1];
    end
    a_neg    = a_signed & rs1_data[31];
    b_neg    = b_signed & rs2_data[31];
    a_mag    = a_neg ? (32'd0 - rs1_data) : rs1_data;
    b_mag    = b_neg ? (32'd0 - rs2_data) : rs2_data;
    div_zero = (rs2_data == 32'd0);
    div_ovf  = ~funct3[0] & (rs1_data == 32'h8000_0000) & (rs2_data == 32'hFFFF_FFFF);
    special  = funct3[2] & (div_zero | div_ovf);
    if (div_zero) special_res = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
    else          special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration of each algorithm; hi/lo hold product halves or remainder/quotient.
  logic [32:0] mul_sum;
  logic [31:0] mul_hi, mul_lo;
  logic [63:0] product, signed_prod;
  logic [31:0] mul_res;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] div_r, div_q, quot, rem, div_res;

  always_comb begin
    mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    mul_hi      = mul_sum[32:1];
    mul_lo      = {mul_sum[0], lo_q[31:1]};
    product     = {mul_hi, mul_lo};
    signed_prod = sign_q ? (64'd0 - product) : product;
    mul_res     = (op_q == 2'b00) ? signed_prod[31:0] : signed_prod[63:32];

    shifted = {hi_q, lo_q[31]};
    fits    = (shifted >= {1'b0, b_q});
    div_r   = fits ? (shifted[31:0] - b_q) : shifted[31:0];
    div_q   = {lo_q[30:0], fits};
    quot    = sign_q ? (32'd0 - div_q) : div_q;
    rem     = sign_r ? (32'd0 - div_r) : div_r;
    div_res = op_q[1] ? rem : quot;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!funct3[2])   state_d = S_MUL;
          else if (special) state_d = S_DONE;
          else              state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (count_q == 5'd31) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 2'd0;
      rd_q        <= 5'd0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      b_q         <= 32'd0;
      count_q     <= 5'd0;
      result      <= 32'd0;
      result_addr <= 5'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= funct3[1:0];
            rd_q    <= rd_addr;
            sign_q  <= a_neg ^ b_neg;
            sign_r  <= a_neg;
            hi_q    <= 32'd0;
            lo_q    <= a_mag;
            b_q     <= b_mag;
            count_q <= 5'd0;
            if (special) begin
              result      <= special_res;
              result_addr <= rd_addr;
            end
          end
        end
        S_MUL: begin
          hi_q    <= mul_hi;
          lo_q    <= mul_lo;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            result      <= mul_res;
            result_addr <= rd_q;
          end
        end
        S_DIV: begin
          hi_q    <= div_r;
          lo_q    <= div_q;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            result      <= div_res;
            result_addr <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake: start is taken only while busy is low; done is a one-cycle pulse.
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign reg_write_en = done & (result_addr != 5'd0);
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit: driver pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        busy, done, reg_write_en;
  logic [31:0] result;
  logic [4:0]  result_addr;
  logic [1:0]  fsm_state;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .result(result), .result_addr(result_addr),
    .reg_write_en(reg_write_en), .fsm_state(fsm_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  addr;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_addr = 5'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit and 32-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib, iq;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    r  = 32'd0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin iq = ia / ib; r = iq; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin iq = ia % ib; r = iq; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  // driver tasks
  task automatic scramble();
    funct3   = 3'($urandom_range(0, 7));
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_addr  = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle_timeout busy=%b required=0", busy);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_done", {31'd0, done}, 32'd0);
    check32("reset_wen", {31'd0, reg_write_en}, 32'd0);
    check32("reset_result", result, 32'd0);
    check32("reset_addr", {27'd0, result_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int extra);
    exp_t e;
    int j;
    wait_idle();
    e.res  = ref_result(f3, a, b);
    e.addr = rd;
    e.cyc  = cyc + 1 + (is_special(f3, a, b) ? 0 : 32);
    exp_q.push_back(e);
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(negedge clk);
    start = 1'b0;
    scramble();
    check32("busy_after_accept", {31'd0, busy}, 32'd1);
    j = 1;
    while (!done && j < 40) begin
      start = (j == extra);
      scramble();
      @(negedge clk);
      j++;
    end
    if (done) begin
      start = 1'b1;
      scramble();
      @(negedge clk);
      start = 1'b0;
    end else begin
      start = 1'b0;
      checks++;
      errors++;
      $display("FAIL done_timeout done=%b required=1", done);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_res  = 32'd0;
      last_addr = 5'd0;
    end else if (armed) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done result=%h required=no_done", result);
        end else begin
          e = exp_q.pop_front();
          check32("result", result, e.res);
          check32("result_addr", {27'd0, result_addr}, {27'd0, e.addr});
          check32("reg_write_en", {31'd0, reg_write_en}, {31'd0, e.addr != 5'd0});
          check32("done_cycle", cyc, e.cyc);
        end
        last_res  = result;
        last_addr = result_addr;
      end else begin
        check32("wen_outside_done", {31'd0, reg_write_en}, 32'd0);
        check32("result_hold", result, last_res);
        check32("addr_hold", {27'd0, result_addr}, {27'd0, last_addr});
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL done_late cycle=%0d required=%0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    do_reset();
    armed = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    run_op(3'd5, 32'd9, 32'd0, 5'd9, 0);
    run_op(3'd7, 32'd9, 32'd0, 5'd10, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 5'd14, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 0);
    run_op(3'd0, 32'd123, 32'd456, 5'd0, 5);

    // abort a multiply mid-flight, then confirm a fresh operation completes
    wait_idle();
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    check32("no_done_after_abort", {31'd0, done}, 32'd0);
    run_op(3'd5, 32'd100, 32'd7, 5'd4, 0);

    for (int i = 0; i < 70; i++) begin
      run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
             5'($urandom_range(0, 31)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 31)) : 0);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check32("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
